// File: rtl/dmem_responder.sv
// Data-memory responder: slave end of the CPU load/store port.
// One outstanding request, fixed wait-state latency, B/H/W little-endian
// accesses with RISC-V funct3 size encoding, error on illegal requests.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int unsigned CW = 4;

    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          l_we;
    logic [2:0]    l_size;
    logic [31:0]   l_addr;
    logic [31:0]   l_wdata;

    logic [31:0]   mem [DEPTH_WORDS];

    logic          accept_c;
    logic          access_c;
    logic          a_we_c;
    logic [2:0]    a_size_c;
    logic [31:0]   a_addr_c;
    logic [31:0]   a_wdata_c;
    logic          err_c;
    logic [AW-1:0] idx_c;
    logic [31:0]   old_c;
    logic [31:0]   byte_c;
    logic [31:0]   half_c;
    logic [31:0]   rdata_c;
    logic [31:0]   wsh_c;
    logic [3:0]    bmask_c;
    logic [31:0]   merged_c;

    // Access fields: live inputs on a zero-wait accept, latched copy otherwise
    always_comb begin
        accept_c  = (state == IDLE) && req_valid && req_ready;
        access_c  = (accept_c && (WAIT_CYCLES == 0)) || ((state == WAIT) && (cnt == '0));
        a_we_c    = (state == IDLE) ? req_we    : l_we;
        a_size_c  = (state == IDLE) ? req_size  : l_size;
        a_addr_c  = (state == IDLE) ? req_addr  : l_addr;
        a_wdata_c = (state == IDLE) ? req_wdata : l_wdata;
    end

    // Legality check: size encoding, store size, alignment, range
    always_comb begin
        err_c = 1'b0;
        case (a_size_c)
            SZ_B:        err_c = 1'b0;
            SZ_BU:       err_c = a_we_c;
            SZ_H:        err_c = a_addr_c[0];
            SZ_HU:       err_c = a_addr_c[0] | a_we_c;
            SZ_W:        err_c = (a_addr_c[1:0] != 2'b00);
            default:     err_c = 1'b1;
        endcase
        if ({2'b00, a_addr_c[31:2]} >= 32'(DEPTH_WORDS)) begin
            err_c = 1'b1;
        end
    end

    // Load extraction and store lane merge
    always_comb begin
        idx_c   = a_addr_c[AW+1:2];
        old_c   = mem[idx_c];
        byte_c  = old_c >> {a_addr_c[1:0], 3'b000};
        half_c  = old_c >> {a_addr_c[1], 4'b0000};
        rdata_c = '0;
        case (a_size_c)
            SZ_B:    rdata_c = {{24{byte_c[7]}}, byte_c[7:0]};
            SZ_BU:   rdata_c = {24'd0, byte_c[7:0]};
            SZ_H:    rdata_c = {{16{half_c[15]}}, half_c[15:0]};
            SZ_HU:   rdata_c = {16'd0, half_c[15:0]};
            SZ_W:    rdata_c = old_c;
            default: rdata_c = '0;
        endcase
        if (err_c || a_we_c) begin
            rdata_c = '0;
        end
        wsh_c   = a_wdata_c << {a_addr_c[1:0], 3'b000};
        bmask_c = 4'b0000;
        case (a_size_c)
            SZ_B:    bmask_c = 4'b0001 << a_addr_c[1:0];
            SZ_H:    bmask_c = 4'b0011 << {a_addr_c[1], 1'b0};
            SZ_W:    bmask_c = 4'b1111;
            default: bmask_c = 4'b0000;
        endcase
        merged_c = old_c;
        for (int i = 0; i < 4; i++) begin
            if (bmask_c[i]) begin
                merged_c[8*i +: 8] = wsh_c[8*i +: 8];
            end
        end
    end

    // Array write on the edge that enters RESP; contents are not reset
    always_ff @(posedge clk) begin
        if (access_c && a_we_c && !err_c) begin
            mem[idx_c] <= merged_c;
        end
    end

    // Request/response FSM with registered handshake and response outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            l_we      <= 1'b0;
            l_size    <= '0;
            l_addr    <= '0;
            l_wdata   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    req_ready <= 1'b1;
                    if (accept_c) begin
                        l_we      <= req_we;
                        l_size    <= req_size;
                        l_addr    <= req_addr;
                        l_wdata   <= req_wdata;
                        req_ready <= 1'b0;
                        if (WAIT_CYCLES > 0) begin
                            state <= WAIT;
                            cnt   <= CW'(WAIT_CYCLES - 1);
                        end else begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_rdata <= rdata_c;
                            rsp_err   <= err_c;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= rdata_c;
                        rsp_err   <= err_c;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
